trace_monitor: RTL

Debug-side consumer of the single-cycle core's debug outputs: `o_pcOut`, `o_inst`, `o_writeBack`, `o_aluOut`, `o_RegWEn` and `o_memRW`. On each qualifying retired instruction it captures a 4-word trace record into a FIFO. It streams the records out as 32-bit words over a valid/ready interface to a host link (UART or JTAG bridge). It sits beside the core at the top level, reads the debug bus only, and never drives the core.

---
 rtl/trace_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/trace_monitor.sv
// Debug trace capture for the single-cycle core: records qualifying retired
// instructions as 4-word records in a FIFO and streams them out over valid/ready.
module trace_monitor #(
    parameter int DEPTH      = 8,
    parameter bit FILTER_ALL = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic                         i_clear,
    input  logic [31:0]                  i_pc,
    input  logic [31:0]                  i_inst,
    input  logic [31:0]                  i_writeBack,
    input  logic [31:0]                  i_aluOut,
    input  logic                         i_RegWEn,
    input  logic                         i_memRW,
    output logic [31:0]                  o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } record_t;

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

    record_t         mem [DEPTH];
    record_t         newRec;
    record_t         outRec;
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [CW-1:0]   count;
    logic [7:0]      seq;
    logic            dropPend;
    logic            overflow;
    state_t          state;
    state_t          stateNext;
    logic            qualify;
    logic            full;
    logic            push;
    logic            drop;
    logic            pop;

    assign qualify = i_enable & (FILTER_ALL | i_RegWEn | i_memRW);
    // Full is judged on the pre-edge count, so a same-edge pop never rescues a push.
    assign full    = (count == CW'(DEPTH));
    assign push    = qualify & ~full;
    assign drop    = qualify & full;

    assign newRec.w0 = {8'hA5, seq, 13'd0, dropPend, i_memRW, i_RegWEn};
    assign newRec.w1 = i_pc;
    assign newRec.w2 = i_inst;
    assign newRec.w3 = i_RegWEn ? i_writeBack : i_aluOut;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    stateNext = W0;
                end
            end
            W0: if (i_ready) stateNext = W1;
            W1: if (i_ready) stateNext = W2;
            W2: if (i_ready) stateNext = W3;
            W3: begin
                if (i_ready) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        stateNext = W0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: record storage has no reset; slots are only read once count says they hold data.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= newRec;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            seq      <= '0;
            dropPend <= 1'b0;
            overflow <= 1'b0;
            outRec   <= '0;
        end else begin
            state <= stateNext;
            count <= count + CW'(push) - CW'(pop);
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop) begin
                rdPtr  <= rdPtr + AW'(1);
                outRec <= mem[rdPtr];
            end
            if (qualify) seq <= seq + 8'd1;
            // A drop beats a coincident clear so the loss is never hidden.
            if (drop) begin
                overflow <= 1'b1;
                dropPend <= 1'b1;
            end else if (i_clear) begin
                overflow <= 1'b0;
                dropPend <= 1'b0;
            end else if (push) begin
                dropPend <= 1'b0;
            end
        end
    end

    always_comb begin
        o_data = 32'd0;
        case (state)
            W0:      o_data = outRec.w0;
            W1:      o_data = outRec.w1;
            W2:      o_data = outRec.w2;
            W3:      o_data = outRec.w3;
            default: o_data = 32'd0;
        endcase
    end

    assign o_valid    = (state != IDLE);
    assign o_overflow = overflow;
    assign o_count    = count;

endmodule
